vmem_scanout_req: RTL and testbench
===================================

// Module: vmem_scanout_req
// PURPOSE
// Parametrised successor of the video-memory read requester. Issues SDRAM burst read requests
// that fetch one frame per frame_start into the scan-out FIFO, entirely in the memory clock domain.
// Adds double-buffered frame bases with vsync-aligned flip, a configurable line stride,
// optional line doubling, and credit-based FIFO flow control in place of coarse level thresholds.
// Sits between the frame-sync synchroniser, sdrc_core (app_req*) and the pixel FIFO write side.
// PARAMETERS
// ADDR_W     25   SDRAM word-address width; all address arithmetic is modulo 2**ADDR_W
// LEN_W      9    width of read_len (matches app_req_len)
// BURST      4    words per request; LINE_WORDS % BURST == 0
// LINE_WORDS 320  words fetched per displayed line
// LINES      480  source lines per frame (displayed lines = LINES, or 2*LINES when scan_double=1)
// STRIDE     512  address distance between consecutive source lines, >= LINE_WORDS
// FREE_W     9    width of fifo_free
// PORTS
// clk           in  1       memory clock (sdrc_core clk)
// reset_n       in  1       asynchronous, active-low reset
// enable        in  1       0: no new frame starts; current request completes, then IDLE
// mem_ready     in  1       sdr_init_done & init complete; no request issued while 0
// frame_start   in  1       one-cycle pulse per vsync, already synchronised to clk
// cfg_base0     in  ADDR_W  frame buffer 0 base
// cfg_base1     in  ADDR_W  frame buffer 1 base
// flip_req      in  1       one-cycle pulse: toggle buffer at next frame_start
// scan_double   in  1       1: each source line fetched twice; sampled at frame_start
// fifo_free     in  FREE_W  free words in FIFO write side
// rd_valid      in  1       one read word written to FIFO this cycle
// read_req_ack  in  1       sdrc_core accepted current request
// read_request  out 1       request valid; held high until ack
// read_addr     out ADDR_W  burst start address; stable while read_request=1
// read_len      out LEN_W   constant BURST
// active_buf    out 1       buffer being scanned (0/1)
// frame_busy    out 1       high from frame start until last burst acked
// overrun_err   out 1       sticky: rd_valid seen with outstanding==0; cleared only by reset
// BEHAVIOUR
// - Reset: read_request=0, read_addr=0, active_buf=0, frame_busy=0, overrun_err=0, flip pending=0,
//   outstanding=0, state IDLE. read_len is a constant.
// - FSM: IDLE -(frame_start & enable & mem_ready)-> ISSUE; ISSUE -(credit ok)-> WAIT_ACK;
//   WAIT_ACK -(ack, more bursts in line)-> ISSUE; -(ack, line done)-> LINE_END;
//   LINE_END (1 cycle: advance line pointers) -> ISSUE, or -> IDLE after last line.
// - At frame_start: active_buf ^= flip_pending, flip_pending cleared, base latched,
//   scan_double latched, line_ptr=base, burst_ptr=line_ptr. flip_req and frame_start in the same
//   cycle: the flip applies at this frame_start.
// - Address: running pointers only, no multiplier. burst_ptr += BURST per ack; at line end
//   line_ptr += STRIDE, except with scan_double on the first pass of a line, where line_ptr is held
//   and only burst_ptr is reloaded from it.
// - Credit: request raised in ISSUE only when fifo_free >= outstanding + BURST (FREE_W+1-bit compare).
//   outstanding += BURST on ack, -= 1 on rd_valid; both in the same cycle: += BURST-1.
//   rd_valid with outstanding==0: sets overrun_err, outstanding stays 0.
// - Handshake: read_request rises 1 cycle after entering ISSUE with credit, falls the cycle after
//   ack; read_addr never changes while read_request=1.
// - frame_start mid-frame: remaining bursts of the old frame are abandoned; a request already
//   asserted is held to its ack, then the new frame begins; outstanding is not cleared.
// - enable=0 or mem_ready=0 mid-frame: no new request is raised; a pending request completes;
//   then IDLE.
// - frame_busy drops in the cycle after the last burst's ack.
// STRUCTURE
// - Shared package vmem_pkg: state encoding localparams (IDLE, ISSUE, WAIT_ACK, LINE_END) and
//   BURST/LEN_W defaults shared with the FIFO level logic.
// - One natural sub-module, vmem_credit_cnt: outstanding-word counter plus credit compare.
//   Everything else stays flat.
// TESTING (LINE_WORDS=8, BURST=4, LINES=2, STRIDE=16, base0=0x100, base1=0x800, ample free)
// - One frame, scan_double=0 -> 4 requests at 0x100, 0x104, 0x110, 0x114; frame_busy falls after ack 4.
// - scan_double=1 -> 8 requests: 0x100, 0x104, 0x100, 0x104, 0x110, 0x114, 0x110, 0x114.
// - flip_req mid-frame -> current frame stays on base0; next frame starts at 0x800 with active_buf=1.
// - fifo_free=6, no rd_valid -> exactly 1 request; 2 rd_valid pulses -> second request issued.
// - frame_start while read_request is held unacked -> address stable until ack; next request is 0x800/0x100.
// - rd_valid with outstanding=0 -> overrun_err=1 and held; async reset_n low mid-burst -> all outputs at reset values.

Source files
------------

// File: rtl/vmem_pkg.sv
// Shared definitions for the video-memory scan-out requester and the
// FIFO level logic: FSM state encoding and the default burst/length sizes.
package vmem_pkg;

    localparam int VMEM_BURST = 4;
    localparam int VMEM_LEN_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_LINE_END = 2'd3
    } vmem_state_e;

endpackage

// File: rtl/vmem_credit_cnt.sv
// Outstanding-word counter for the scan-out FIFO. Words are added when a
// burst is accepted by the SDRAM controller and removed as each read word
// lands in the FIFO; a new burst is allowed only when the FIFO has room for
// everything already in flight plus one more burst.
module vmem_credit_cnt
    import vmem_pkg::*;
#(
    parameter int FREE_W = 9,
    parameter int BURST  = VMEM_BURST
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ack,
    input  logic              rd_valid,
    input  logic [FREE_W-1:0] fifo_free,
    output logic              credit_ok,
    output logic              overrun_err
);

    localparam int CNT_W = FREE_W + 1;

    logic [CNT_W-1:0] outstanding_r;
    logic [CNT_W-1:0] outstanding_nxt_s;
    logic [CNT_W-1:0] need_s;

    // Credit compare: free space must cover in-flight words plus a new burst.
    always_comb begin
        need_s    = outstanding_r + CNT_W'(BURST);
        credit_ok = ({1'b0, fifo_free} >= need_s);
    end

    // Next outstanding count from this cycle's ack and FIFO write.
    always_comb begin
        outstanding_nxt_s = outstanding_r;
        case ({ack, rd_valid})
            2'b11:   outstanding_nxt_s = outstanding_r + CNT_W'(BURST - 1);
            2'b10:   outstanding_nxt_s = outstanding_r + CNT_W'(BURST);
            2'b01: begin
                if (outstanding_r == CNT_W'(0)) begin
                    outstanding_nxt_s = CNT_W'(0);
                end else begin
                    outstanding_nxt_s = outstanding_r - CNT_W'(1);
                end
            end
            default: outstanding_nxt_s = outstanding_r;
        endcase
    end

    // Outstanding register and sticky overrun flag (word arrived unrequested).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding_r <= CNT_W'(0);
            overrun_err   <= 1'b0;
        end else begin
            outstanding_r <= outstanding_nxt_s;
            if (rd_valid && (outstanding_r == CNT_W'(0))) begin
                overrun_err <= 1'b1;
            end else begin
                overrun_err <= overrun_err;
            end
        end
    end

endmodule

// File: rtl/vmem_scanout_req.sv
// SDRAM burst read requester feeding the pixel scan-out FIFO. Fetches one
// frame per frame_start from a double-buffered base, walking lines with a
// fixed stride via running pointers, optionally fetching each line twice,
// and pacing requests with FIFO credit.
module vmem_scanout_req
    import vmem_pkg::*;
#(
    parameter int ADDR_W     = 25,
    parameter int LEN_W      = VMEM_LEN_W,
    parameter int BURST      = VMEM_BURST,
    parameter int LINE_WORDS = 320,
    parameter int LINES      = 480,
    parameter int STRIDE     = 512,
    parameter int FREE_W     = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              mem_ready,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] cfg_base0,
    input  logic [ADDR_W-1:0] cfg_base1,
    input  logic              flip_req,
    input  logic              scan_double,
    input  logic [FREE_W-1:0] fifo_free,
    input  logic              rd_valid,
    input  logic              read_req_ack,
    output logic              read_request,
    output logic [ADDR_W-1:0] read_addr,
    output logic [LEN_W-1:0]  read_len,
    output logic              active_buf,
    output logic              frame_busy,
    output logic              overrun_err
);

    localparam int BPL    = LINE_WORDS / BURST;
    localparam int BIDX_W = $clog2(BPL + 1);
    localparam int LIDX_W = $clog2(LINES + 1);

    localparam logic [ADDR_W-1:0] BURST_A    = ADDR_W'(BURST);
    localparam logic [ADDR_W-1:0] STRIDE_A   = ADDR_W'(STRIDE);
    localparam logic [BIDX_W-1:0] BIDX_LAST  = BIDX_W'(BPL - 1);
    localparam logic [LIDX_W-1:0] LIDX_LAST  = LIDX_W'(LINES - 1);

    vmem_state_e       state_r;
    logic [ADDR_W-1:0] line_ptr_r;
    logic [ADDR_W-1:0] burst_ptr_r;
    logic [BIDX_W-1:0] burst_idx_r;
    logic [LIDX_W-1:0] line_idx_r;
    logic              pass_r;
    logic              dbl_r;
    logic              flip_pend_r;
    logic              restart_r;
    logic              read_request_r;
    logic [ADDR_W-1:0] read_addr_r;
    logic              active_buf_r;
    logic              frame_busy_r;

    logic              run_s;
    logic              start_s;
    logic              ack_s;
    logic              new_buf_s;
    logic [ADDR_W-1:0] new_base_s;
    logic              line_done_s;
    logic              last_line_s;
    logic              credit_ok_s;

    // Frame-start qualification, buffer selection and line/frame end decode.
    always_comb begin
        run_s       = enable & mem_ready;
        start_s     = frame_start & run_s;
        ack_s       = read_req_ack & read_request_r;
        new_buf_s   = active_buf_r ^ (flip_pend_r | flip_req);
        new_base_s  = new_buf_s ? cfg_base1 : cfg_base0;
        line_done_s = (burst_idx_r == BIDX_LAST);
        last_line_s = (line_idx_r == LIDX_LAST) && (!dbl_r || pass_r);
    end

    vmem_credit_cnt #(
        .FREE_W (FREE_W),
        .BURST  (BURST)
    ) u_credit (
        .clk         (clk),
        .reset_n     (reset_n),
        .ack         (ack_s),
        .rd_valid    (rd_valid),
        .fifo_free   (fifo_free),
        .credit_ok   (credit_ok_s),
        .overrun_err (overrun_err)
    );

    // Request FSM with frame latch, running address pointers and handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            line_ptr_r     <= '0;
            burst_ptr_r    <= '0;
            burst_idx_r    <= '0;
            line_idx_r     <= '0;
            pass_r         <= 1'b0;
            dbl_r          <= 1'b0;
            flip_pend_r    <= 1'b0;
            restart_r      <= 1'b0;
            read_request_r <= 1'b0;
            read_addr_r    <= '0;
            active_buf_r   <= 1'b0;
            frame_busy_r   <= 1'b0;
        end else begin
            // A new frame reloads the walk immediately; an in-flight request
            // keeps its own address register until it is acked.
            if (start_s) begin
                active_buf_r <= new_buf_s;
                flip_pend_r  <= 1'b0;
                line_ptr_r   <= new_base_s;
                burst_ptr_r  <= new_base_s;
                burst_idx_r  <= '0;
                line_idx_r   <= '0;
                pass_r       <= 1'b0;
                dbl_r        <= scan_double;
                frame_busy_r <= 1'b1;
            end else if (flip_req) begin
                flip_pend_r <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (start_s) begin
                        state_r <= ST_ISSUE;
                    end else if (!run_s) begin
                        state_r      <= ST_IDLE;
                        frame_busy_r <= 1'b0;
                    end else if (credit_ok_s) begin
                        read_request_r <= 1'b1;
                        read_addr_r    <= burst_ptr_r;
                        state_r        <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_s) begin
                        read_request_r <= 1'b0;
                        restart_r      <= 1'b0;
                        if (start_s || restart_r) begin
                            state_r <= ST_ISSUE;
                        end else if (!run_s) begin
                            state_r      <= ST_IDLE;
                            frame_busy_r <= 1'b0;
                        end else if (line_done_s) begin
                            state_r <= ST_LINE_END;
                            if (last_line_s) begin
                                frame_busy_r <= 1'b0;
                            end
                        end else begin
                            state_r     <= ST_ISSUE;
                            burst_ptr_r <= burst_ptr_r + BURST_A;
                            burst_idx_r <= burst_idx_r + BIDX_W'(1);
                        end
                    end else if (start_s) begin
                        restart_r <= 1'b1;
                    end
                end
                ST_LINE_END: begin
                    if (start_s) begin
                        state_r <= ST_ISSUE;
                    end else if (last_line_s || !run_s) begin
                        state_r      <= ST_IDLE;
                        frame_busy_r <= 1'b0;
                    end else begin
                        state_r     <= ST_ISSUE;
                        burst_idx_r <= '0;
                        if (dbl_r && !pass_r) begin
                            pass_r      <= 1'b1;
                            burst_ptr_r <= line_ptr_r;
                        end else begin
                            pass_r      <= 1'b0;
                            line_ptr_r  <= line_ptr_r + STRIDE_A;
                            burst_ptr_r <= line_ptr_r + STRIDE_A;
                            line_idx_r  <= line_idx_r + LIDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign read_request = read_request_r;
    assign read_addr    = read_addr_r;
    assign read_len     = LEN_W'(BURST);
    assign active_buf   = active_buf_r;
    assign frame_busy   = frame_busy_r;

endmodule

// File: tb/tb_vmem_scanout_req.sv
// Randomised bench for vmem_scanout_req with a small geometry. Expected burst
// addresses come from a frame-level model (base + line*STRIDE + burst*BURST,
// each line repeated when doubling), and FIFO credit is tracked as a plain
// word count.
module tb_vmem_scanout_req;

    localparam int ADDR_W     = 25;
    localparam int LEN_W      = 9;
    localparam int BURST      = 4;
    localparam int LINE_WORDS = 8;
    localparam int LINES      = 2;
    localparam int STRIDE     = 16;
    localparam int FREE_W     = 9;
    localparam logic [ADDR_W-1:0] BASE0 = 25'h100;
    localparam logic [ADDR_W-1:0] BASE1 = 25'h800;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic              mem_ready;
    logic              frame_start;
    logic [ADDR_W-1:0] cfg_base0;
    logic [ADDR_W-1:0] cfg_base1;
    logic              flip_req;
    logic              scan_double;
    logic [FREE_W-1:0] fifo_free;
    logic              rd_valid;
    logic              read_req_ack;
    logic              read_request;
    logic [ADDR_W-1:0] read_addr;
    logic [LEN_W-1:0]  read_len;
    logic              active_buf;
    logic              frame_busy;
    logic              overrun_err;

    int errors = 0;
    int checks = 0;

    // Model state
    bit                m_buf;
    bit                m_flip;
    int                m_out;
    logic [ADDR_W-1:0] exp_q[$];

    vmem_scanout_req #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BURST(BURST), .LINE_WORDS(LINE_WORDS),
        .LINES(LINES), .STRIDE(STRIDE), .FREE_W(FREE_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mem_ready(mem_ready),
        .frame_start(frame_start), .cfg_base0(cfg_base0), .cfg_base1(cfg_base1),
        .flip_req(flip_req), .scan_double(scan_double), .fifo_free(fifo_free),
        .rd_valid(rd_valid), .read_req_ack(read_req_ack), .read_request(read_request),
        .read_addr(read_addr), .read_len(read_len), .active_buf(active_buf),
        .frame_busy(frame_busy), .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [ADDR_W-1:0] cur_base();
        return m_buf ? BASE1 : BASE0;
    endfunction

    // Expected burst address list of one frame.
    function automatic void build(input logic [ADDR_W-1:0] base, input bit dbl);
        for (int l = 0; l < LINES; l++)
            for (int p = 0; p < (dbl ? 2 : 1); p++)
                for (int b = 0; b < LINE_WORDS / BURST; b++)
                    exp_q.push_back(base + ADDR_W'(l * STRIDE + b * BURST));
    endfunction

    task automatic start_frame(input bit dbl, input bit flip);
        frame_start = 1'b1;
        scan_double = dbl;
        flip_req    = flip;
        tick();
        frame_start = 1'b0;
        flip_req    = 1'b0;
        m_buf  = m_buf ^ (m_flip | flip);
        m_flip = 1'b0;
        chk_eq("active_buf", 32'(active_buf), 32'(m_buf));
    endtask

    task automatic pulse_flip();
        flip_req = 1'b1;
        tick();
        flip_req = 1'b0;
        m_flip = 1'b1;
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (read_request !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        ok = (read_request === 1'b1);
        if (!ok) chk_eq("req_timeout", 32'(read_request), 32'd1);
    endtask

    task automatic serve_req(input logic [ADDR_W-1:0] a, input bit last);
        bit ok;
        int d;
        wait_req(ok);
        if (!ok) return;
        chk_eq("addr", 32'(read_addr), 32'(a));
        chk_eq("read_len", 32'(read_len), 32'(BURST));
        d = $urandom_range(0, 2);
        repeat (d) begin
            tick();
            chk_eq("hold_addr", 32'(read_addr), 32'(a));
            chk_eq("hold_req", 32'(read_request), 32'd1);
        end
        read_req_ack = 1'b1;
        tick();
        read_req_ack = 1'b0;
        m_out += BURST;
        chk_eq("req_drop", 32'(read_request), 32'd0);
        chk_eq(last ? "busy_drop" : "busy_hi", 32'(frame_busy), last ? 32'd0 : 32'd1);
    endtask

    task automatic run_frame();
        logic [ADDR_W-1:0] a;
        while (exp_q.size() > 0) begin
            a = exp_q.pop_front();
            serve_req(a, exp_q.size() == 0);
        end
        repeat (5) tick();
        chk_eq("idle_no_req", 32'(read_request), 32'd0);
    endtask

    task automatic drain();
        while (m_out > 0) begin
            rd_valid = 1'b1;
            tick();
            m_out--;
        end
        rd_valid = 1'b0;
        tick();
        chk_eq("no_overrun", 32'(overrun_err), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_req"},  32'(read_request), 32'd0);
        chk_eq({tag, "_addr"}, 32'(read_addr), 32'd0);
        chk_eq({tag, "_buf"},  32'(active_buf), 32'd0);
        chk_eq({tag, "_busy"}, 32'(frame_busy), 32'd0);
        chk_eq({tag, "_ovr"},  32'(overrun_err), 32'd0);
        chk_eq({tag, "_len"},  32'(read_len), 32'(BURST));
    endtask

    initial begin
        logic [ADDR_W-1:0] b;
        logic [ADDR_W-1:0] nb;
        bit ok;
        reset_n = 1'b0; enable = 1'b1; mem_ready = 1'b1; frame_start = 1'b0;
        cfg_base0 = BASE0; cfg_base1 = BASE1; flip_req = 1'b0; scan_double = 1'b0;
        fifo_free = 9'd511; rd_valid = 1'b0; read_req_ack = 1'b0;
        m_buf = 1'b0; m_flip = 1'b0; m_out = 0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        // Plain frame, then line-doubled frame
        start_frame(1'b0, 1'b0);
        chk_eq("busy_start", 32'(frame_busy), 32'd1);
        build(cur_base(), 1'b0); run_frame(); drain();
        start_frame(1'b1, 1'b0);
        build(cur_base(), 1'b1); run_frame(); drain();

        // Flip mid-frame takes effect at the next frame
        start_frame(1'b0, 1'b0);
        build(cur_base(), 1'b0);
        serve_req(exp_q.pop_front(), 1'b0);
        pulse_flip();
        chk_eq("buf_hold", 32'(active_buf), 32'd0);
        run_frame(); drain();
        start_frame(1'b0, 1'b0);
        build(cur_base(), 1'b0); run_frame(); drain();
        // Flip in the same cycle as frame_start
        start_frame(1'b0, 1'b1);
        build(cur_base(), 1'b0); run_frame(); drain();

        // Credit: room for one burst only until two words drain
        fifo_free = 9'd6;
        start_frame(1'b0, 1'b0);
        b = cur_base();
        serve_req(b, 1'b0);
        repeat (10) tick();
        chk_eq("credit_block", 32'(read_request), 32'd0);
        rd_valid = 1'b1; tick(); tick(); rd_valid = 1'b0;
        m_out -= 2;
        serve_req(b + 25'd4, 1'b0);
        fifo_free = 9'd511;
        serve_req(b + 25'd16, 1'b0);
        serve_req(b + 25'd20, 1'b1);
        drain();

        // frame_start with flip while a request is held unacked
        start_frame(1'b0, 1'b0);
        b = cur_base();
        wait_req(ok);
        chk_eq("rs_addr0", 32'(read_addr), 32'(b));
        start_frame(1'b0, 1'b1);
        nb = cur_base();
        repeat (3) begin
            tick();
            chk_eq("rs_hold_addr", 32'(read_addr), 32'(b));
            chk_eq("rs_hold_req", 32'(read_request), 32'd1);
        end
        read_req_ack = 1'b1; tick(); read_req_ack = 1'b0;
        m_out += BURST;
        chk_eq("rs_busy", 32'(frame_busy), 32'd1);
        build(nb, 1'b0); run_frame(); drain();

        // enable dropped while a request is pending
        start_frame(1'b0, 1'b0);
        b = cur_base();
        serve_req(b, 1'b0);
        wait_req(ok);
        chk_eq("en_addr", 32'(read_addr), 32'(b + 25'd4));
        enable = 1'b0;
        tick();
        chk_eq("en_hold", 32'(read_request), 32'd1);
        read_req_ack = 1'b1; tick(); read_req_ack = 1'b0;
        m_out += BURST;
        chk_eq("en_busy", 32'(frame_busy), 32'd0);
        repeat (10) tick();
        chk_eq("en_no_req", 32'(read_request), 32'd0);
        enable = 1'b1;
        drain();

        // Randomised frames
        for (int k = 0; k < 5; k++) begin
            bit dbl = 1'($urandom_range(0, 1));
            bit fl  = 1'($urandom_range(0, 1));
            fifo_free = 9'($urandom_range(300, 511));
            if ($urandom_range(0, 1) == 1) pulse_flip();
            start_frame(dbl, fl);
            build(cur_base(), dbl); run_frame(); drain();
        end

        // Overrun: word arrives with nothing outstanding
        rd_valid = 1'b1; tick(); rd_valid = 1'b0;
        tick();
        chk_eq("overrun_set", 32'(overrun_err), 32'd1);
        repeat (5) tick();
        chk_eq("overrun_hold", 32'(overrun_err), 32'd1);

        // Asynchronous reset mid-burst
        start_frame(1'b1, 1'b0);
        wait_req(ok);
        #2 reset_n = 1'b0;
        #1 chk_reset_outputs("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        m_buf = 1'b0; m_flip = 1'b0; m_out = 0; exp_q.delete();
        tick();
        start_frame(1'b0, 1'b0);
        build(cur_base(), 1'b0); run_frame(); drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
